md5_job_sched: RTL and testbench
================================

Name: md5_job_sched

Overview:
- Round-robin scheduler that shares one md5 core among NUM_REQ requesters.
- Grants one requester at a time and streams that requester's 16 x 32-bit message block into the core's word buffer.
- Pulses the core start, waits for the core's done, and returns the 128-bit digest tagged with the requester ID.
- Sits directly between requester logic and the md5 core instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- TIMEOUT, 1023, watchdog limit in cycles spent in WAIT (used only with WDOG_EN).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester job request, level.
- gnt  out  NUM_REQ  one-hot grant; held from LOAD through RESP.
- wr_data  in  NUM_REQ*32  per-requester message word; slice i belongs to requester i.
- wr_valid  in  NUM_REQ  per-requester word valid.
- wr_ready  out  NUM_REQ  word accept, = gnt[i] while in LOAD.
- core_load  out  1  word write strobe to the core buffer.
- core_addr  out  4  word index 0..15.
- core_wdata  out  32  word to the core.
- core_start  out  1  one-cycle start pulse.
- core_done  in  1  one-cycle pulse; core_digest is valid in the same cycle.
- core_digest  in  128  digest from the core.
- res_valid  out  1  result valid.
- res_id  out  ID_W  granted requester index.
- res_digest  out  128  latched digest.
- res_err  out  1  watchdog expiry flag, qualified by res_valid.
- res_ready  in  1  result accept.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: rst is synchronous, active-high. On reset:
  - state = IDLE; gnt, res_valid, res_err, core_start, busy all 0.
  - res_id, res_digest, word counter and round-robin pointer = 0.
  - Reset asserted mid-job aborts the job; no result is produced.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the pointer with wrap-around.
  - Next cycle: gnt = that one-hot value, res_id = its index, counter = 0, state = LOAD.
  - Decision-to-grant latency is 1 cycle.
- LOAD:
  - wr_ready[g] = 1; all other wr_ready = 0.
  - core_load = wr_valid[g], combinational; core_addr = counter; core_wdata = wr_data slice g.
  - On each accepted word, counter increments.
  - When word 15 is accepted, go to START.
  - Gaps in wr_valid stall the counter. There is no limit on the stall length.
- START: core_start = 1 for exactly one cycle, then WAIT.
- WAIT:
  - On core_done: latch core_digest into res_digest, set res_valid = 1 and res_err = 0, go to RESP.
- RESP:
  - Outputs are held stable while res_ready = 0.
  - On res_valid && res_ready:
    - clear res_valid and gnt;
    - pointer = (g+1) mod NUM_REQ;
    - state = IDLE.
  - Earliest next grant is 1 cycle later.
- Boundary conditions:
  - Deasserting req[g] after grant does not cancel the job; the granted requester is committed to supply 16 words.
  - Changes to req while not in IDLE are ignored.
  - core_done outside WAIT is ignored.
  - core_done in the same cycle as rst: reset wins.
  - A single requester with req held high is re-granted after each job. No requester waits more than NUM_REQ-1 jobs.
- busy = (state != IDLE).

Optional Feature:
- Macro: MD5_JOB_SCHED_WDOG_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments every cycle in WAIT.
  - When it reaches TIMEOUT without core_done, go to RESP with res_valid = 1, res_err = 1, res_digest = 0.
  - A core_done in the expiry cycle takes priority; the result is then normal with res_err = 0.
- Not defined: no watchdog counter; WAIT lasts indefinitely; res_err is tied to 0.

Test Plan:
1. Only req = 0100; words are the padded "abc" block (word0 = 0x80636261, word14 = 0x00000018, others 0); core model returns 0x900150983cd24fb0d6963f7d28e17f72 -> gnt = 0100 one cycle after req; core_addr 0..15 in order with matching words; one core_start pulse after word 15; res_valid with res_id = 2, res_digest = the model digest, res_err = 0.
2. req = 1111 held high for 5 jobs, res_ready = 1 -> grant order is requester 0, 1, 2, 3, 0; gnt is never multi-hot.
3. wr_valid from the granted requester toggles 1,0,0,1,... -> core_load only when valid is high; core_addr holds during gaps; exactly 16 loads, then START.
4. res_ready held low for 6 cycles after res_valid -> res_valid, res_id and res_digest stable; no new gnt even with other req bits set; IDLE one cycle after the handshake.
5. rst pulsed for 1 cycle during WAIT, then core_done pulsed -> gnt = 0, busy = 0, res_valid stays 0, core_done ignored.
6. With MD5_JOB_SCHED_WDOG_EN, TIMEOUT = 20, core model never responds -> res_valid = 1 with res_err = 1 and res_digest = 0, exactly 20 cycles after entering WAIT.

Source files
------------

// File: rtl/md5_job_sched.sv
// md5_job_sched: round-robin scheduler that shares one md5 core among NUM_REQ requesters.
// Optional WAIT-state watchdog is enabled by defining MD5_JOB_SCHED_WDOG_EN.
module md5_job_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    input  logic [NUM_REQ*32-1:0]   wr_data,
    input  logic [NUM_REQ-1:0]      wr_valid,
    output logic [NUM_REQ-1:0]      wr_ready,
    output logic                    core_load,
    output logic [3:0]              core_addr,
    output logic [31:0]             core_wdata,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic [127:0]            core_digest,
    output logic                    res_valid,
    output logic [ID_W-1:0]         res_id,
    output logic [127:0]            res_digest,
    output logic                    res_err,
    input  logic                    res_ready,
    output logic                    busy
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                res_valid_q, res_valid_d;
    logic [127:0]        res_digest_q, res_digest_d;
    logic                pick_found;
    logic [ID_W-1:0]     pick_id;

    if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("md5_job_sched: illegal NUM_REQ/ID_W/TIMEOUT combination");
    end

`ifdef MD5_JOB_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            res_err_q, res_err_d;
`endif

    // First set request bit at or above the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[ID_W'((32'(ptr_q) + i) % NUM_REQ)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        res_id_d     = res_id_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        res_valid_d  = res_valid_q;
        res_digest_d = res_digest_q;
        wr_ready     = '0;
        core_load    = 1'b0;
`ifdef MD5_JOB_SCHED_WDOG_EN
        wd_d         = wd_q;
        res_err_d    = res_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d          = '0;
                    gnt_d[pick_id] = 1'b1;
                    res_id_d       = pick_id;
                    cnt_d          = '0;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                wr_ready  = gnt_q;
                core_load = wr_valid[res_id_q];
                if (core_load) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef MD5_JOB_SCHED_WDOG_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (core_done) begin
                    res_digest_d = core_digest;
                    res_valid_d  = 1'b1;
                    state_d      = S_RESP;
`ifdef MD5_JOB_SCHED_WDOG_EN
                    res_err_d    = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // Counter would reach TIMEOUT this cycle: give up on the core.
                    res_digest_d = '0;
                    res_valid_d  = 1'b1;
                    res_err_d    = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    gnt_d       = '0;
                    ptr_d       = (res_id_q == ID_W'(NUM_REQ - 1)) ? '0 : res_id_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            res_id_q     <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_digest_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            res_id_q     <= res_id_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
            res_digest_q <= res_digest_d;
        end
    end

`ifdef MD5_JOB_SCHED_WDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            res_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            res_err_q <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign core_addr  = cnt_q;
    assign core_wdata = wr_data[{res_id_q, 5'd0} +: 32];
    assign core_start = (state_q == S_START);
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_digest = res_digest_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_md5_job_sched.sv
// tb_md5_job_sched: table-driven and randomized self-checking bench for md5_job_sched.
// Watchdog expectations follow MD5_JOB_SCHED_WDOG_EN when it is defined for the build.
module tb_md5_job_sched;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam logic [127:0] ABC_DIGEST = 128'h900150983cd24fb0d6963f7d28e17f72;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [N*32-1:0]  wr_data;
    logic [N-1:0]     wr_valid;
    logic [N-1:0]     wr_ready;
    logic             core_load;
    logic [3:0]       core_addr;
    logic [31:0]      core_wdata;
    logic             core_start;
    logic             core_done;
    logic [127:0]     core_digest;
    logic             res_valid;
    logic [1:0]       res_id;
    logic [127:0]     res_digest;
    logic             res_err;
    logic             res_ready;
    logic             busy;

    md5_job_sched #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .core_load(core_load), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_start(core_start), .core_done(core_done), .core_digest(core_digest),
        .res_valid(res_valid), .res_id(res_id), .res_digest(res_digest),
        .res_err(res_err), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;
    logic [31:0] words [16];

    typedef struct {
        logic [N-1:0] rq;
        int           id;
        int           lat;
        int           hold;
        int           gap;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Stand-in core: the real md5 of the padded "abc" block, otherwise a keyed mix of the words.
    function automatic logic [127:0] core_model();
        logic [127:0] acc;
        bit           abc;
        acc = 128'h0123456789abcdeffedcba9876543210;
        abc = (words[0] == 32'h80636261) && (words[14] == 32'h00000018);
        for (int k = 0; k < 16; k++) begin
            if (k != 0 && k != 14 && words[k] != 32'h0) abc = 1'b0;
            acc = {acc[126:0], acc[127]} ^ {words[k], ~words[k], words[k] ^ 32'h5a5a5a5a, 32'(k)};
        end
        return abc ? ABC_DIGEST : acc;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic drive_junk(input logic [N-1:0] g, input bit v);
        wr_valid    = (4'($urandom) & ~g) | (v ? g : 4'b0);
        wr_data     = {$urandom, $urandom, $urandom, $urandom};
        req         = 4'($urandom);
        core_done   = 1'($urandom);
        core_digest = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; wr_valid = '0; core_done = 1'b0; res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_gnt", 128'(gnt), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_err", 128'(res_err), 128'(0));
        chk("rst_core_start", 128'(core_start), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_res_id", 128'(res_id), 128'(0));
        chk("rst_res_digest", res_digest, 128'(0));
        chk("rst_wr_ready", 128'(wr_ready), 128'(0));
        ptr_m = 0;
    endtask

    // Full job for requester id, starting in an IDLE cycle. lat < 0: core never replies.
    task automatic run_job(input int id, input logic [N-1:0] rq, input int lat,
                           input int hold, input int gap, input bit use_abc);
        logic [N-1:0]  g;
        logic [127:0]  dig;
        bit            exp_err;
        g = 4'(1 << id);
        req = rq;
        #1;
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_gnt", 128'(gnt), 128'(0));
        step();
        if (use_abc) begin
            words = '{default: 32'h0};
            words[0]  = 32'h80636261;
            words[14] = 32'h00000018;
        end else begin
            foreach (words[k]) words[k] = $urandom;
        end
        chk("grant", 128'(gnt), 128'(g));
        chk("grant_res_id", 128'(res_id), 128'(id));
        for (int k = 0; k < 16; k++) begin
            int ngap;
            ngap = (gap < 0) ? int'($urandom_range(0, 2)) : ((k == 0) ? 0 : gap);
            for (int s = 0; s < ngap; s++) begin
                drive_junk(g, 1'b0);
                #1;
                chk("gap_load", 128'(core_load), 128'(0));
                chk("gap_addr", 128'(core_addr), 128'(k));
                chk("gap_wr_ready", 128'(wr_ready), 128'(g));
                chk("gap_gnt", 128'(gnt), 128'(g));
                step();
            end
            drive_junk(g, 1'b1);
            wr_data[id*32 +: 32] = words[k];
            #1;
            chk("load", 128'(core_load), 128'(1));
            chk("load_addr", 128'(core_addr), 128'(k));
            chk("load_wdata", 128'(core_wdata), 128'(words[k]));
            chk("load_wr_ready", 128'(wr_ready), 128'(g));
            chk("load_no_start", 128'(core_start), 128'(0));
            step();
        end
        wr_valid  = '0;
        core_done = 1'($urandom);
        #1;
        chk("start", 128'(core_start), 128'(1));
        chk("start_gnt", 128'(gnt), 128'(g));
        chk("start_no_load", 128'(core_load), 128'(0));
        step();
        core_done = 1'b0;
        #1;
        chk("start_once", 128'(core_start), 128'(0));
        chk("wait_busy", 128'(busy), 128'(1));
        exp_err = 1'b0;
        dig     = core_model();
        if (lat >= 0) begin
            for (int c = 0; c < lat; c++) begin
                chk("wait_no_result", 128'(res_valid), 128'(0));
                step();
            end
            core_done   = 1'b1;
            core_digest = dig;
            step();
            core_done   = 1'b0;
            core_digest = {$urandom, $urandom, $urandom, $urandom};
        end else begin
`ifdef MD5_JOB_SCHED_WDOG_EN
            for (int c = 0; c < TO; c++) begin
                chk("wdog_no_result", 128'(res_valid), 128'(0));
                step();
            end
            dig     = '0;
            exp_err = 1'b1;
`else
            for (int c = 0; c < 2 * TO; c++) begin
                chk("long_wait_no_result", 128'(res_valid), 128'(0));
                chk("long_wait_busy", 128'(busy), 128'(1));
                step();
            end
            core_done   = 1'b1;
            core_digest = dig;
            step();
            core_done   = 1'b0;
`endif
        end
        #1;
        chk("res_valid", 128'(res_valid), 128'(1));
        chk("res_id", 128'(res_id), 128'(id));
        chk("res_digest", res_digest, dig);
        chk("res_err", 128'(res_err), 128'(exp_err));
        chk("resp_gnt", 128'(gnt), 128'(g));
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            drive_junk(g, 1'b1);
            #1;
            chk("hold_valid", 128'(res_valid), 128'(1));
            chk("hold_id", 128'(res_id), 128'(id));
            chk("hold_digest", res_digest, dig);
            chk("hold_err", 128'(res_err), 128'(exp_err));
            chk("hold_gnt", 128'(gnt), 128'(g));
            chk("hold_wr_ready", 128'(wr_ready), 128'(0));
            step();
        end
        res_ready = 1'b1;
        core_done = 1'b0;
        #1;
        chk("hs_valid", 128'(res_valid), 128'(1));
        step();
        res_ready = 1'b0;
        req       = '0;
        #1;
        chk("post_valid", 128'(res_valid), 128'(0));
        chk("post_gnt", 128'(gnt), 128'(0));
        chk("post_busy", 128'(busy), 128'(0));
        ptr_m = (id + 1) % N;
    endtask

    initial begin
        rst = 1'b1; req = '0; wr_data = '0; wr_valid = '0;
        core_done = 1'b0; core_digest = '0; res_ready = 1'b0;

        // Padded "abc" block from requester 2 alone.
        do_reset();
        run_job(2, 4'b0100, 3, 2, 0, 1'b1);
        chk("abc_ptr_model", 128'(ptr_m), 128'(3));

        do_reset();
        tbl[0]  = '{4'b1111, 0, 0, 0, 0};
        tbl[1]  = '{4'b1111, 1, 1, 0, 0};
        tbl[2]  = '{4'b1111, 2, 3, 1, 0};
        tbl[3]  = '{4'b1111, 3, 0, 0, 0};
        tbl[4]  = '{4'b1111, 0, 2, 0, 0};
        tbl[5]  = '{4'b0001, 0, 0, 0, 0};
        tbl[6]  = '{4'b1001, 3, 1, 0, 0};
        tbl[7]  = '{4'b0110, 1, 2, 0, 2};
        tbl[8]  = '{4'b1011, 3, 0, 6, 0};
        tbl[9]  = '{4'b0010, 1, TO - 1, 0, 0};
        tbl[10] = '{4'b0010, 1, 0, 0, 0};
        tbl[11] = '{4'b0100, 2, -1, 1, 0};
        for (int t = 0; t < 12; t++) begin
            run_job(tbl[t].id, tbl[t].rq, tbl[t].lat, tbl[t].hold, tbl[t].gap, 1'b0);
        end

        // Reset in WAIT aborts the job; v=1 also lands core_done on the reset cycle.
        for (int v = 0; v < 2; v++) begin
            req = 4'b0001;
            step();
            chk("abort_grant", 128'(gnt), 128'(1));
            for (int k = 0; k < 16; k++) begin
                wr_valid = 4'b0001;
                wr_data  = {$urandom, $urandom, $urandom, $urandom};
                step();
            end
            wr_valid = '0;
            step();
            step();
            step();
            rst       = 1'b1;
            core_done = (v == 1);
            step();
            rst       = 1'b0;
            core_done = 1'b0;
            req       = '0;
            #1;
            chk("abort_gnt", 128'(gnt), 128'(0));
            chk("abort_busy", 128'(busy), 128'(0));
            chk("abort_valid", 128'(res_valid), 128'(0));
            core_done   = 1'b1;
            core_digest = {$urandom, $urandom, $urandom, $urandom};
            step();
            core_done = 1'b0;
            #1;
            chk("abort_done_ignored", 128'(res_valid), 128'(0));
            chk("abort_idle", 128'(busy), 128'(0));
            chk("abort_digest", res_digest, 128'(0));
            ptr_m = 0;
        end

        for (int j = 0; j < 40; j++) begin
            logic [N-1:0] rq;
            int           id;
            do rq = 4'($urandom); while (rq == 4'b0);
            if ($urandom_range(0, 3) == 0) begin
                for (int s = 0; s < int'($urandom_range(1, 3)); s++) begin
                    req       = '0;
                    core_done = 1'($urandom);
                    #1;
                    chk("rand_idle_gnt", 128'(gnt), 128'(0));
                    chk("rand_idle_busy", 128'(busy), 128'(0));
                    step();
                end
                core_done = 1'b0;
            end
            id = rr_pick(rq, ptr_m);
            run_job(id, rq, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got time %0t required finish before 2000000", $time);
        $fatal(1);
    end

endmodule
